// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register with valid/ready
// handshake, one-entry skid buffer and synchronous flush. in_ready comes
// straight from a flop, so there is no combinational out_ready -> in_ready path.
// Optional macro PIPE_STAGE_PERF_EN adds a saturating stall_cycles counter.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W    = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned DST_W     = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        startin,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic [DST_W-1:0]            in_dst,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic [DST_W-1:0]            out_dst
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]            stall_cycles
`endif
);

    localparam int unsigned PAYLOAD_W = NUM_LANES * DATA_W;

    // Main entry drives the outputs; skid entry catches the one extra accept.
    logic                 main_valid_q, main_valid_n;
    logic [CTRL_W-1:0]    main_ctrl_q,  main_ctrl_n;
    logic [PAYLOAD_W-1:0] main_data_q,  main_data_n;
    logic [DST_W-1:0]     main_dst_q,   main_dst_n;
    logic                 skid_valid_q, skid_valid_n;
    logic [CTRL_W-1:0]    skid_ctrl_q,  skid_ctrl_n;
    logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_n;
    logic [DST_W-1:0]     skid_dst_q,   skid_dst_n;
    logic                 in_ready_q,   in_ready_n;

    logic accept;
    logic main_free;

    assign accept    = in_valid && in_ready_q;
    assign main_free = !main_valid_q || out_ready;

    // Next-state for both entries and the registered ready.
    always_comb begin
        main_valid_n = main_valid_q;
        main_ctrl_n  = main_ctrl_q;
        main_data_n  = main_data_q;
        main_dst_n   = main_dst_q;
        skid_valid_n = skid_valid_q;
        skid_ctrl_n  = skid_ctrl_q;
        skid_data_n  = skid_data_q;
        skid_dst_n   = skid_dst_q;

        if (main_free) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no accept can collide with the drain
                main_valid_n = 1'b1;
                main_ctrl_n  = skid_ctrl_q;
                main_data_n  = skid_data_q;
                main_dst_n   = skid_dst_q;
                skid_valid_n = 1'b0;
                skid_ctrl_n  = '0;
            end else if (accept) begin
                main_valid_n = 1'b1;
                main_ctrl_n  = in_ctrl;
                main_data_n  = in_data;
                main_dst_n   = in_dst;
            end else begin
                main_valid_n = 1'b0;
                main_ctrl_n  = '0;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_ctrl_n  = in_ctrl;
            skid_data_n  = in_data;
            skid_dst_n   = in_dst;
        end

        // Flush kills everything held and anything offered; data/dst go stale.
        if (flush) begin
            main_valid_n = 1'b0;
            main_ctrl_n  = '0;
            skid_valid_n = 1'b0;
            skid_ctrl_n  = '0;
        end

        in_ready_n = !skid_valid_n;
    end

    // State registers; startin clears everything including payload fields.
    always_ff @(posedge clk) begin
        if (startin) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            main_dst_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_dst_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_n;
            main_ctrl_q  <= main_ctrl_n;
            main_data_q  <= main_data_n;
            main_dst_q   <= main_dst_n;
            skid_valid_q <= skid_valid_n;
            skid_ctrl_q  <= skid_ctrl_n;
            skid_data_q  <= skid_data_n;
            skid_dst_q   <= skid_dst_n;
            in_ready_q   <= in_ready_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign out_dst   = main_dst_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_n;

    // Saturating count of cycles where an entry is presented but not taken.
    always_comb begin
        stall_n = stall_q;
        if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_n = stall_q + CNT_W'(1);
        end
    end

    // Stall counter register; only startin clears it.
    always_ff @(posedge clk) begin
        if (startin) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_n;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg plus hand sequences for
// simultaneous flush/startin and (with PIPE_STAGE_PERF_EN) the stall counter.
module tb_pipe_stage_reg;

    localparam int unsigned CTRL_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 2;
    localparam int unsigned DST_W  = 5;
    localparam int unsigned CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    startin, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CTRL_W-1:0]       in_ctrl, out_ctrl;
    logic [LANES*DATA_W-1:0] in_data, out_data;
    logic [DST_W-1:0]        in_dst, out_dst;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]        stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_LANES(LANES), .DST_W(DST_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .startin(startin), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_dst(out_dst)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        string       name;
        logic        rst, fl, iv;
        logic [1:0]  ictl;
        logic [4:0]  idst;
        logic [31:0] il0;
        logic        ordy;
        logic        ov, ir;
        logic [1:0]  octl;
        logic [4:0]  odst;
        logic [31:0] ol0;
    } vec_t;

    vec_t vq[$];

    // Lane 1 is derived from lane 0 so both lanes are exercised; 0 maps to 0.
    function automatic logic [63:0] mk(input logic [31:0] l0);
        return {l0 << 4, l0};
    endfunction

    function automatic void add(input string nm, input logic rst, input logic fl,
                                input logic iv, input logic [1:0] ictl, input int idst,
                                input int il0, input logic ordy, input logic ov,
                                input logic ir, input logic [1:0] octl, input int odst,
                                input int ol0);
        vec_t v;
        v.name = nm; v.rst = rst; v.fl = fl; v.iv = iv; v.ictl = ictl;
        v.idst = 5'(idst); v.il0 = 32'(il0); v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.octl = octl; v.odst = 5'(odst); v.ol0 = 32'(ol0);
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [1:0] ictl, input logic [4:0] idst,
                         input logic [31:0] il0, input logic ordy);
        startin = rst; flush = fl; in_valid = iv; in_ctrl = ictl;
        in_dst = idst; in_data = mk(il0); out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with an entry offered: it must be ignored.
        add("rst0", 1,0,1, 2'b11, 9, 'hAAA, 1,  0,1,2'b00, 0, 0);
        add("rst1", 1,0,1, 2'b11, 9, 'hAAA, 1,  0,1,2'b00, 0, 0);
        add("rel",  0,0,0, 2'b00, 0, 0,     1,  0,1,2'b00, 0, 0);
        // Streaming with out_ready high.
        for (int i = 1; i <= 8; i++)
            add("stream", 0,0,1, 2'(i % 3 + 1), i, 'h100 + i, 1,
                1,1, 2'(i % 3 + 1), i, 'h100 + i);
        add("str_idle", 0,0,0, 2'b00, 0, 0, 1,  0,1,2'b00, 0, 0);
        // Skid: out_ready low for 3 cycles mid-burst.
        add("sk_A", 0,0,1, 2'b10, 11, 'h20B, 1,  1,1,2'b10, 11, 'h20B);
        add("sk_B", 0,0,1, 2'b10, 12, 'h20C, 1,  1,1,2'b10, 12, 'h20C);
        add("sk_C", 0,0,1, 2'b10, 13, 'h20D, 0,  1,0,2'b10, 12, 'h20C);
        add("sk_h1",0,0,1, 2'b10, 14, 'h20E, 0,  1,0,2'b10, 12, 'h20C);
        add("sk_h2",0,0,1, 2'b10, 14, 'h20E, 0,  1,0,2'b10, 12, 'h20C);
        add("sk_dr",0,0,1, 2'b10, 14, 'h20E, 1,  1,1,2'b10, 13, 'h20D);
        for (int i = 14; i <= 18; i++)
            add("sk_run", 0,0,1, 2'b10, i, 'h200 + i, 1, 1,1,2'b10, i, 'h200 + i);
        add("sk_idle", 0,0,0, 2'b00, 0, 0, 1,  0,1,2'b00, 0, 0);
        // Flush while full, then flush of an offered entry into an empty stage.
        add("fl_X",  0,0,1, 2'b01, 21, 'h315, 0,  1,1,2'b01, 21, 'h315);
        add("fl_Y",  0,0,1, 2'b01, 22, 'h316, 0,  1,0,2'b01, 21, 'h315);
        add("fl_Z",  0,1,1, 2'b01, 23, 'h317, 0,  0,1,2'b00, 0, 0);
        add("fl_gone",0,0,0,2'b00, 0, 0,     1,  0,1,2'b00, 0, 0);
        add("fl_emp",0,1,1, 2'b01, 24, 'h318, 1,  0,1,2'b00, 0, 0);
        add("fl_W",  0,0,1, 2'b11, 25, 'h319, 1,  1,1,2'b11, 25, 'h319);
        add("fl_end",0,0,0, 2'b00, 0, 0,     1,  0,1,2'b00, 0, 0);

        drive(0,0,0,2'b00,5'd0,32'd0,1'b1);
        foreach (vq[k]) begin
            drive(vq[k].rst, vq[k].fl, vq[k].iv, vq[k].ictl, vq[k].idst, vq[k].il0, vq[k].ordy);
            step();
            chk({vq[k].name, ".out_valid"}, 64'(out_valid), 64'(vq[k].ov));
            chk({vq[k].name, ".in_ready"},  64'(in_ready),  64'(vq[k].ir));
            chk({vq[k].name, ".out_ctrl"},  64'(out_ctrl),  64'(vq[k].octl));
            if (vq[k].ov || vq[k].rst) begin
                chk({vq[k].name, ".out_dst"},  64'(out_dst), 64'(vq[k].odst));
                chk({vq[k].name, ".out_data"}, out_data,     mk(vq[k].ol0));
            end
        end

        // Simultaneous flush and startin behaves as startin: data zeroed.
        drive(0,0,1,2'b11,5'd27,32'h41B,1'b0); step();
        drive(0,0,1,2'b11,5'd28,32'h41C,1'b0); step();
        chk("sim.full_ready", 64'(in_ready), 64'(0));
        drive(1,1,1,2'b11,5'd29,32'h41D,1'b0); step();
        chk("sim.out_valid", 64'(out_valid), 64'(0));
        chk("sim.out_ctrl",  64'(out_ctrl),  64'(0));
        chk("sim.out_data",  out_data,       64'(0));
        chk("sim.out_dst",   64'(out_dst),   64'(0));
        chk("sim.in_ready",  64'(in_ready),  64'(1));
        drive(0,0,0,2'b00,5'd0,32'd0,1'b1); step();
        chk("sim.after_valid", 64'(out_valid), 64'(0));
        chk("sim.after_ready", 64'(in_ready),  64'(1));

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter: saturation, immune to flush, cleared by startin.
        drive(1,0,0,2'b00,5'd0,32'd0,1'b0); step();
        drive(0,0,0,2'b00,5'd0,32'd0,1'b0); step();
        chk("perf.zero", 64'(stall_cycles), 64'(0));
        drive(0,0,1,2'b01,5'd3,32'h55,1'b0); step();
        chk("perf.loaded", 64'(stall_cycles), 64'(0));
        drive(0,0,0,2'b00,5'd0,32'd0,1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 4) chk("perf.five", 64'(stall_cycles), 64'(5));
        end
        chk("perf.sat", 64'(stall_cycles), 64'(15));
        chk("perf.held", 64'(out_valid), 64'(1));
        drive(0,1,0,2'b00,5'd0,32'd0,1'b0); step();
        chk("perf.flush_valid", 64'(out_valid), 64'(0));
        chk("perf.flush_cnt", 64'(stall_cycles), 64'(15));
        drive(0,0,0,2'b00,5'd0,32'd0,1'b0); step();
        chk("perf.idle_cnt", 64'(stall_cycles), 64'(15));
        drive(1,0,0,2'b00,5'd0,32'd0,1'b0); step();
        chk("perf.rst_cnt", 64'(stall_cycles), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
